// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter on the dmem device bus.
// CPU stores push bytes into a FIFO; a serializer sends 8-bit frames on txd
// with optional parity and 1 or 2 stop bits. Status, control and a runtime
// baud divider are readable; a level interrupt flags "all sent".
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR  = 32'ha00003f8,
   parameter int          DEPTH_LOG2 = 4,
   parameter logic [15:0] CLK_DIV    = 16'd868,
   parameter int          PARITY     = 0,
   parameter int          STOP_BITS  = 1
) (
   input  logic        clock,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        we,
   output logic [31:0] rdata,
   output logic        txd,
   output logic        irq
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;
   localparam logic [31:0] CTRL_ADDR   = BASE_ADDR + 32'd8;
   localparam logic [31:0] DIV_ADDR    = BASE_ADDR + 32'd12;
   localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   // FIFO storage and bookkeeping
   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [DEPTH_LOG2:0]   count;
   logic                  full, empty, push_req, push_ok, drop, pop;
   logic [7:0]            head;

   // Control/status registers
   logic        overflow, enable, irq_en;
   logic [15:0] div_reg;
   logic        sel_data, sel_status, sel_ctrl, sel_div;

   // Serializer state
   state_t      state, state_nx;
   logic [7:0]  shift, shift_nx;
   logic [2:0]  bit_idx, bit_idx_nx;
   logic        stop_idx, stop_idx_nx;
   logic        par_bit, par_bit_nx;
   logic [15:0] bit_div, bit_div_nx;
   logic [15:0] bit_cnt, bit_cnt_nx;
   logic        txd_nx, bit_done, launch;

   logic unused;
   assign unused = ^wdata[31:16];

   assign sel_data   = (addr == BASE_ADDR);
   assign sel_status = (addr == STATUS_ADDR);
   assign sel_ctrl   = (addr == CTRL_ADDR);
   assign sel_div    = (addr == DIV_ADDR);

   assign full     = (count == FULL_COUNT);
   assign empty    = (count == '0);
   assign head     = mem[rd_ptr];
   assign push_req = we && sel_data;
   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign push_ok  = push_req && (!full || pop);
   assign drop     = push_req && !push_ok;
   assign bit_done = (bit_cnt == 16'd0);

   // Next-state logic for the serializer; each bit lasts bit_div cycles
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch.
      state_nx    = state;
      shift_nx    = shift;
      bit_idx_nx  = bit_idx;
      stop_idx_nx = stop_idx;
      par_bit_nx  = par_bit;
      bit_div_nx  = bit_div;
      bit_cnt_nx  = bit_cnt;
      txd_nx      = txd;
      launch      = 1'b0;
      if (state != IDLE)
         bit_cnt_nx = bit_done ? bit_div - 16'd1 : bit_cnt - 16'd1;
      case (state)
         IDLE: launch = enable && !empty;
         START: if (bit_done) begin
            state_nx   = DATA;
            bit_idx_nx = 3'd0;
            txd_nx     = shift[0];
         end
         DATA: if (bit_done) begin
            if (bit_idx == 3'd7) begin
               stop_idx_nx = 1'b0;
               if (PARITY != 0) begin
                  state_nx = PAR;
                  txd_nx   = par_bit;
               end else begin
                  state_nx = STOP;
                  txd_nx   = 1'b1;
               end
            end else begin
               bit_idx_nx = bit_idx + 3'd1;
               shift_nx   = shift >> 1;
               txd_nx     = shift[1];
            end
         end
         PAR: if (bit_done) begin
            state_nx = STOP;
            txd_nx   = 1'b1;
         end
         STOP: if (bit_done) begin
            if (STOP_BITS == 2 && !stop_idx) begin
               stop_idx_nx = 1'b1;
            end else if (enable && !empty) begin
               launch = 1'b1;
            end else begin
               state_nx = IDLE;
               txd_nx   = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
      // Starting a frame pops the head byte and freezes the divider for it.
      if (launch) begin
         state_nx   = START;
         shift_nx   = head;
         par_bit_nx = (PARITY == 2) ? ~(^head) : ^head;
         bit_div_nx = div_reg;
         bit_cnt_nx = div_reg - 16'd1;
         txd_nx     = 1'b0;
      end
   end

   assign pop = launch;

   // Serializer registers; reset aborts any frame and idles the line high
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         state    <= IDLE;
         shift    <= 8'd0;
         bit_idx  <= 3'd0;
         stop_idx <= 1'b0;
         par_bit  <= 1'b0;
         bit_div  <= 16'd1;
         bit_cnt  <= 16'd0;
         txd      <= 1'b1;
      end else begin
         state    <= state_nx;
         shift    <= shift_nx;
         bit_idx  <= bit_idx_nx;
         stop_idx <= stop_idx_nx;
         par_bit  <= par_bit_nx;
         bit_div  <= bit_div_nx;
         bit_cnt  <= bit_cnt_nx;
         txd      <= txd_nx;
      end
   end

   // FIFO data array
   always_ff @(posedge clock) begin
      // NOTE: the array is not reset; count and pointers define what is valid.
      if (push_ok) mem[wr_ptr] <= wdata[7:0];
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clock) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Control registers, divider and sticky overflow
   always_ff @(posedge clock) begin
      if (rst) begin
         enable   <= 1'b1;
         irq_en   <= 1'b0;
         overflow <= 1'b0;
         div_reg  <= CLK_DIV;
      end else begin
         if (we && sel_ctrl) begin
            enable <= wdata[0];
            irq_en <= wdata[2];
         end
         if (we && sel_div)
            div_reg <= (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
         // A drop in the same cycle as a clear wins: the flag ends set.
         if (drop)
            overflow <= 1'b1;
         else if (we && sel_ctrl && wdata[1])
            overflow <= 1'b0;
      end
   end

   // Transmit-done interrupt, one cycle behind its inputs
   always_ff @(posedge clock) begin
      if (rst) irq <= 1'b0;
      else     irq <= irq_en && empty && (state == IDLE);
   end

   // Combinational register read mux
   always_comb begin
      rdata = 32'd0;
      if (sel_status) begin
         rdata[0] = full;
         rdata[1] = empty;
         rdata[2] = (state != IDLE);
         rdata[3] = overflow;
         rdata[DEPTH_LOG2+8:8] = count;
      end else if (sel_ctrl) begin
         rdata = {29'd0, irq_en, 1'b0, enable};
      end else if (sel_div) begin
         rdata = {16'd0, div_reg};
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Testbench for mmio_uart_tx: three instances (small FIFO/no parity,
// even parity, odd parity with two stop bits) driven over a shared bus.
// Transmitted frames are decoded from txd and matched against a queue of
// expected bytes filled as stores are issued.
module tb_mmio_uart_tx;

   localparam logic [31:0] DATA_A = 32'ha00003f8;
   localparam logic [31:0] STAT_A = DATA_A + 32'd4;
   localparam logic [31:0] CTRL_A = DATA_A + 32'd8;
   localparam logic [31:0] DIV_A  = DATA_A + 32'd12;

   logic        clock = 1'b0;
   logic        rst   = 1'b1;
   logic [31:0] addr  = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic [2:0]  we    = 3'd0;
   logic [31:0] rdata0, rdata1, rdata2;
   logic        txd0, txd1, txd2, irq0, irq1, irq2;

   int n_checks = 0;
   int n_pass   = 0;
   logic [7:0] exp_q [$];

   mmio_uart_tx #(.DEPTH_LOG2(2)) dut0 (
      .clock(clock), .rst(rst), .addr(addr), .wdata(wdata), .we(we[0]),
      .rdata(rdata0), .txd(txd0), .irq(irq0));
   mmio_uart_tx #(.PARITY(1)) dut1 (
      .clock(clock), .rst(rst), .addr(addr), .wdata(wdata), .we(we[1]),
      .rdata(rdata1), .txd(txd1), .irq(irq1));
   mmio_uart_tx #(.PARITY(2), .STOP_BITS(2)) dut2 (
      .clock(clock), .rst(rst), .addr(addr), .wdata(wdata), .we(we[2]),
      .rdata(rdata2), .txd(txd2), .irq(irq2));

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic txd_of(input int sel);
      return (sel == 0) ? txd0 : (sel == 1) ? txd1 : txd2;
   endfunction

   function automatic logic irq_of(input int sel);
      return (sel == 0) ? irq0 : (sel == 1) ? irq1 : irq2;
   endfunction

   function automatic logic [31:0] rdata_of(input int sel);
      return (sel == 0) ? rdata0 : (sel == 1) ? rdata1 : rdata2;
   endfunction

   function automatic logic [31:0] status(input logic full, input logic empty,
                                          input logic busy, input logic ovf, input int cnt);
      return (32'(cnt) << 8) | {28'd0, ovf, busy, empty, full};
   endfunction

   // One store, taken at the posedge after the next negedge; returns 1 ns after it.
   task automatic wr(input logic [31:0] a, input logic [31:0] d, input int sel);
      @(negedge clock);
      addr = a;
      wdata = d;
      we = 3'd0;
      we[sel] = 1'b1;
      @(posedge clock);
      #1;
      we = 3'd0;
   endtask

   task automatic rd(input logic [31:0] a, input int sel, output logic [31:0] v);
      addr = a;
      #1;
      v = rdata_of(sel);
   endtask

   task automatic push(input logic [7:0] d, input int sel, input bit accepted);
      wr(DATA_A, {24'd0, d}, sel);
      if (accepted) exp_q.push_back(d);
   endtask

   // Waits up to max_wait negedges for a start bit, then samples the whole
   // frame once per cycle and checks every bit window is constant.
   task automatic rx_frame(input int sel, input int div, input int par_en, input int stops,
                           input int max_wait, output int waited, output logic [7:0] data,
                           output logic par, output logic ok, output int busy_n, output int irq_n);
      logic samp [0:255];
      int   nbits, total;
      waited = 0; data = 8'd0; par = 1'b0; ok = 1'b1; busy_n = 0; irq_n = 0;
      nbits = 9 + par_en + stops;
      total = nbits * div;
      addr = STAT_A;
      do begin
         @(negedge clock);
         waited++;
      end while (txd_of(sel) !== 1'b0 && waited < max_wait);
      if (txd_of(sel) !== 1'b0) begin
         ok = 1'b0;
         return;
      end
      for (int i = 0; i < total; i++) begin
         if (i > 0) @(negedge clock);
         samp[i] = txd_of(sel);
         busy_n += int'(rdata_of(sel)[2]);
         irq_n  += int'(irq_of(sel));
      end
      for (int b = 0; b < nbits; b++)
         for (int c = 1; c < div; c++)
            if (samp[b*div+c] !== samp[b*div]) ok = 1'b0;
      if (samp[0] !== 1'b0) ok = 1'b0;
      for (int j = 0; j < 8; j++) data[j] = samp[(1+j)*div];
      if (par_en != 0) par = samp[9*div];
      for (int b = 9 + par_en; b < nbits; b++)
         if (samp[b*div] !== 1'b1) ok = 1'b0;
   endtask

   // Receives one frame and compares it against the scoreboard head.
   task automatic rx_check(input string tag, input int sel, input int div, input int par_mode,
                           input int stops, input int max_wait, input int exp_wait,
                           output int busy_n, output int irq_n);
      int         waited;
      logic [7:0] data, exp_d;
      logic       par, ok;
      rx_frame(sel, div, (par_mode != 0) ? 1 : 0, stops, max_wait, waited, data, par, ok,
               busy_n, irq_n);
      check({tag, "_wait"}, waited, exp_wait);
      check({tag, "_shape"}, {31'd0, ok}, 32'd1);
      if (exp_q.size() == 0) begin
         check({tag, "_sb_underflow"}, 32'd1, 32'd0);
      end else begin
         exp_d = exp_q.pop_front();
         check({tag, "_data"}, {24'd0, data}, {24'd0, exp_d});
         if (par_mode == 1) check({tag, "_par"}, {31'd0, par}, {31'd0, ^exp_d});
         if (par_mode == 2) check({tag, "_par"}, {31'd0, par}, {31'd0, ~(^exp_d)});
      end
   endtask

   initial begin
      logic [31:0] v;
      int busy_n, irq_n, lows;

      // Reset state
      repeat (3) @(posedge clock);
      @(negedge clock);
      rst = 1'b0;
      rd(STAT_A, 0, v); check("rst_status", v, status(0, 1, 0, 0, 0));
      rd(CTRL_A, 0, v); check("rst_ctrl", v, 32'd1);
      rd(DIV_A, 0, v);  check("rst_div", v, 32'd868);
      check("rst_txd", {31'd0, txd0}, 32'd1);
      check("rst_irq", {31'd0, irq0}, 32'd0);
      rd(DATA_A, 0, v); check("data_reads_zero", v, 32'd0);

      // Divider of 0 is stored as 1
      wr(DIV_A, 32'd0, 0);
      rd(DIV_A, 0, v); check("div_zero", v, 32'd1);

      // Single frame of 0x55 at 4 cycles/bit: latency, shape, 40 busy cycles
      wr(DIV_A, 32'd4, 0);
      push(8'h55, 0, 1'b1);
      rx_check("f55", 0, 4, 0, 1, 3, 2, busy_n, irq_n);
      check("f55_busy_cycles", busy_n, 40);
      @(negedge clock);
      check("f55_busy_after", {31'd0, rdata0[2]}, 32'd0);
      check("f55_txd_idle", {31'd0, txd0}, 32'd1);

      // Interrupt: high when idle+empty, low during the frame, back one cycle after
      wr(CTRL_A, 32'd5, 0);
      repeat (2) @(negedge clock);
      check("irq_idle", {31'd0, irq0}, 32'd1);
      push(8'hA3, 0, 1'b1);
      rx_check("firq", 0, 4, 0, 1, 3, 2, busy_n, irq_n);
      check("irq_low_in_frame", irq_n, 0);
      @(negedge clock);
      check("irq_lag", {31'd0, irq0}, 32'd0);
      @(negedge clock);
      check("irq_back", {31'd0, irq0}, 32'd1);

      // Overflow on a 4-deep FIFO, then back-to-back drain
      wr(CTRL_A, 32'd0, 0);
      for (int i = 1; i <= 5; i++) push(8'(i), 0, exp_q.size() < 4);
      rd(STAT_A, 0, v); check("ovf_status", v, status(1, 0, 0, 1, 4));
      wr(CTRL_A, 32'd1, 0);
      rx_check("ovf_f1", 0, 4, 0, 1, 3, 2, busy_n, irq_n);
      for (int i = 2; i <= 4; i++) rx_check($sformatf("ovf_f%0d", i), 0, 4, 0, 1, 1, 1, busy_n, irq_n);
      @(negedge clock);
      rd(STAT_A, 0, v); check("ovf_sticky", v, status(0, 1, 0, 1, 0));
      wr(CTRL_A, 32'd3, 0);
      rd(STAT_A, 0, v); check("ovf_cleared", v, status(0, 1, 0, 0, 0));

      // Divider change mid-frame only affects the following frame
      wr(CTRL_A, 32'd0, 0);
      push(8'hA5, 0, 1'b1);
      push(8'h3C, 0, 1'b1);
      wr(CTRL_A, 32'd1, 0);
      fork
         rx_check("div_old", 0, 4, 0, 1, 3, 2, busy_n, irq_n);
         begin
            repeat (8) @(negedge clock);
            wr(DIV_A, 32'd8, 0);
         end
      join
      rx_check("div_new", 0, 8, 0, 1, 1, 1, busy_n, irq_n);
      rd(DIV_A, 0, v); check("div_readback", v, 32'd8);

      // Even parity, 11-bit frame
      wr(DIV_A, 32'd2, 1);
      push(8'h07, 1, 1'b1);
      rx_check("even", 1, 2, 1, 1, 3, 2, busy_n, irq_n);
      check("even_len", busy_n, 22);
      @(negedge clock);
      check("even_busy_after", {31'd0, rdata1[2]}, 32'd0);

      // Odd parity with two stop bits, 12-bit frame
      wr(DIV_A, 32'd2, 2);
      push(8'h07, 2, 1'b1);
      rx_check("odd", 2, 2, 2, 2, 3, 2, busy_n, irq_n);
      check("odd_len", busy_n, 24);
      @(negedge clock);
      check("odd_busy_after", {31'd0, rdata2[2]}, 32'd0);

      // Reset mid-DATA with three bytes queued discards everything
      wr(DIV_A, 32'd4, 0);
      for (int i = 0; i < 4; i++) push(8'h11 * 8'(i + 1), 0, 1'b1);
      repeat (6) @(negedge clock);
      rst = 1'b1;
      @(negedge clock);
      rst = 1'b0;
      exp_q.delete();
      check("mid_rst_txd", {31'd0, txd0}, 32'd1);
      rd(STAT_A, 0, v); check("mid_rst_status", v, status(0, 1, 0, 0, 0));
      rd(CTRL_A, 0, v); check("mid_rst_ctrl", v, 32'd1);
      rd(DIV_A, 0, v);  check("mid_rst_div", v, 32'd868);
      lows = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clock);
         if (txd0 !== 1'b1) lows++;
      end
      check("mid_rst_silent", lows, 0);
      check("sb_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
